// File: rtl/uart_pix_pkg.sv
// Shared definitions for the UART pixel command path: parser state encoding,
// frame constants and the display limits shared with the VGA timing block.
package uart_pix_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StXh    = 3'd1,
        StXl    = 3'd2,
        StYh    = 3'd3,
        StYl    = 3'd4,
        StColor = 3'd5,
        StChk   = 3'd6
    } pix_state_e;

    localparam logic [7:0]  SofByte    = 8'hA5;
    localparam int unsigned FrameLen   = 7;
    localparam logic [9:0]  HActiveDef = 10'd640;
    localparam logic [9:0]  VActiveDef = 10'd480;

    // Coordinates carry only two significant bits in the high byte.
    function automatic logic [9:0] pix_coord(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[1:0], lo};
    endfunction

endpackage

// File: rtl/uart_pix_out_reg.sv
// Single-entry valid/ready output register. A commit while the held entry is
// stalled is dropped and flagged; a commit coinciding with a transfer reloads.
module uart_pix_out_reg (
    input  logic       CLK_100M,
    input  logic       SYS_RST,
    input  logic       commit_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [7:0] color_i,
    input  logic       rdy_i,
    output logic       vld_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic [7:0] color_o,
    output logic       ovf_o
);

    logic       vld_q, vld_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] color_q, color_d;
    logic       ovf_q, ovf_d;

    // Next-state: drain on handshake, load or flag overflow on commit.
    always_comb begin
        vld_d   = vld_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        ovf_d   = 1'b0;
        if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
        if (commit_i) begin
            if (vld_q && !rdy_i) begin
                ovf_d = 1'b1;
            end else begin
                vld_d   = 1'b1;
                x_d     = x_i;
                y_d     = y_i;
                color_d = color_i;
            end
        end
    end

    // Output register state.
    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            vld_q   <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            color_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            ovf_q   <= ovf_d;
        end
    end

    assign vld_o   = vld_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign color_o = color_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_pix_cmd_parser.sv
// UART pixel-write frame parser: assembles SOF,XH,XL,YH,YL,COLOR,CHK frames,
// validates them and hands pixel writes to the framebuffer writer.
// Optional statistics counters are built when UART_PIX_CMD_STATS_EN is defined.
module uart_pix_cmd_parser
    import uart_pix_pkg::*;
#(
    parameter logic [7:0]  P_SOF      = SofByte,
    parameter logic [9:0]  P_H_ACTIVE = HActiveDef,
    parameter logic [9:0]  P_V_ACTIVE = VActiveDef,
    parameter logic [19:0] P_TIMEOUT  = 20'd100000
) (
    input  logic        CLK_100M,
    input  logic        SYS_RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_DVLD,
    input  logic        RX_ERR,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [7:0]  PIX_COLOR,
    output logic        PIX_VLD,
    input  logic        PIX_RDY,
    output logic        FRAME_ERR,
    output logic        FRAME_OVF,
    output logic [15:0] STAT_FRAMES,
    output logic [15:0] STAT_ERRORS
);

    pix_state_e  state_q, state_d;
    logic [7:0]  chk_q, chk_d;
    logic [19:0] tmo_q, tmo_d;
    logic [7:0]  xh_q, xh_d;
    logic [7:0]  xl_q, xl_d;
    logic [7:0]  yh_q, yh_d;
    logic [7:0]  yl_q, yl_d;
    logic [7:0]  color_q, color_d;
    logic        frame_err_q, frame_err_d;
    logic        commit;
    logic        frame_ok;
    logic [9:0]  pix_x, pix_y;

    assign pix_x = pix_coord(xh_q, xl_q);
    assign pix_y = pix_coord(yh_q, yl_q);

    // chk_q already includes COLOR when the checksum byte arrives.
    assign frame_ok = (RX_DATA == chk_q) && (xh_q[7:2] == 6'd0) && (yh_q[7:2] == 6'd0) &&
                      (pix_x < P_H_ACTIVE) && (pix_y < P_V_ACTIVE);

    // Frame FSM next-state: RX_ERR beats a byte, a byte beats the timeout.
    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q;
        xh_d        = xh_q;
        xl_d        = xl_q;
        yh_d        = yh_q;
        yl_d        = yl_q;
        color_d     = color_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        if (state_q == StIdle) begin
            tmo_d = 20'd0;
            if (RX_DVLD && (RX_DATA == P_SOF)) begin
                state_d = StXh;
                chk_d   = 8'd0;
            end
        end else if (RX_ERR) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = 20'd0;
        end else if (RX_DVLD) begin
            tmo_d = 20'd0;
            chk_d = chk_q ^ RX_DATA;
            case (state_q)
                StXh: begin
                    xh_d    = RX_DATA;
                    state_d = StXl;
                end
                StXl: begin
                    xl_d    = RX_DATA;
                    state_d = StYh;
                end
                StYh: begin
                    yh_d    = RX_DATA;
                    state_d = StYl;
                end
                StYl: begin
                    yl_d    = RX_DATA;
                    state_d = StColor;
                end
                StColor: begin
                    color_d = RX_DATA;
                    state_d = StChk;
                end
                StChk: begin
                    chk_d   = chk_q;
                    state_d = StIdle;
                    if (frame_ok) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_q == P_TIMEOUT - 20'd1) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = 20'd0;
        end else begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    // Frame FSM and byte registers.
    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q     <= StIdle;
            chk_q       <= 8'd0;
            tmo_q       <= 20'd0;
            xh_q        <= 8'd0;
            xl_q        <= 8'd0;
            yh_q        <= 8'd0;
            yl_q        <= 8'd0;
            color_q     <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            xh_q        <= xh_d;
            xl_q        <= xl_d;
            yh_q        <= yh_d;
            yl_q        <= yl_d;
            color_q     <= color_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Commit uses the fresh COLOR register, which is stable by the CHK byte.
    uart_pix_out_reg u_out_reg (
        .CLK_100M (CLK_100M),
        .SYS_RST  (SYS_RST),
        .commit_i (commit),
        .x_i      (pix_x),
        .y_i      (pix_y),
        .color_i  (color_q),
        .rdy_i    (PIX_RDY),
        .vld_o    (PIX_VLD),
        .x_o      (PIX_X),
        .y_o      (PIX_Y),
        .color_o  (PIX_COLOR),
        .ovf_o    (FRAME_OVF)
    );

    assign FRAME_ERR = frame_err_q;

`ifdef UART_PIX_CMD_STATS_EN
    logic [15:0] stat_frames_q;
    logic [15:0] stat_errors_q;

    // Saturating good-frame and error counters.
    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            stat_frames_q <= 16'd0;
            stat_errors_q <= 16'd0;
        end else begin
            if (commit && (stat_frames_q != 16'hFFFF)) begin
                stat_frames_q <= stat_frames_q + 16'd1;
            end
            if ((frame_err_q || FRAME_OVF) && (stat_errors_q != 16'hFFFF)) begin
                stat_errors_q <= stat_errors_q + 16'd1;
            end
        end
    end

    assign STAT_FRAMES = stat_frames_q;
    assign STAT_ERRORS = stat_errors_q;
`else
    assign STAT_FRAMES = 16'd0;
    assign STAT_ERRORS = 16'd0;
`endif

endmodule

// File: tb/tb_uart_pix_cmd_parser.sv
// Directed self-checking bench for uart_pix_cmd_parser. The timeout is shortened
// so the timeout scenario stays short.
module tb_uart_pix_cmd_parser;

    localparam logic [19:0] Tmo = 20'd200;

    logic        CLK_100M = 1'b0;
    logic        SYS_RST  = 1'b1;
    logic [7:0]  RX_DATA  = 8'd0;
    logic        RX_DVLD  = 1'b0;
    logic        RX_ERR   = 1'b0;
    logic [9:0]  PIX_X;
    logic [9:0]  PIX_Y;
    logic [7:0]  PIX_COLOR;
    logic        PIX_VLD;
    logic        PIX_RDY  = 1'b1;
    logic        FRAME_ERR;
    logic        FRAME_OVF;
    logic [15:0] STAT_FRAMES;
    logic [15:0] STAT_ERRORS;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int wr_cnt = 0;
    logic [9:0] wr_x = 10'd0;
    logic [7:0] wr_c = 8'd0;
    int exp_frames = 0;
    int exp_errs = 0;

    uart_pix_cmd_parser #(
        .P_TIMEOUT (Tmo)
    ) dut (
        .CLK_100M    (CLK_100M),
        .SYS_RST     (SYS_RST),
        .RX_DATA     (RX_DATA),
        .RX_DVLD     (RX_DVLD),
        .RX_ERR      (RX_ERR),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .PIX_COLOR   (PIX_COLOR),
        .PIX_VLD     (PIX_VLD),
        .PIX_RDY     (PIX_RDY),
        .FRAME_ERR   (FRAME_ERR),
        .FRAME_OVF   (FRAME_OVF),
        .STAT_FRAMES (STAT_FRAMES),
        .STAT_ERRORS (STAT_ERRORS)
    );

    always #5 CLK_100M = ~CLK_100M;

    // Mid-cycle monitor of pulses and completed pixel writes.
    always @(negedge CLK_100M) begin
        if (!SYS_RST) begin
            if (FRAME_ERR) err_cnt++;
            if (FRAME_OVF) ovf_cnt++;
            if (PIX_VLD && PIX_RDY) begin
                wr_cnt++;
                wr_x = PIX_X;
                wr_c = PIX_COLOR;
            end
        end
    end

    task automatic tick();
        @(posedge CLK_100M);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA = b;
        RX_DVLD = 1'b1;
        tick();
        RX_DVLD = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] xh, input logic [7:0] xl, input logic [7:0] yh,
                              input logic [7:0] yl, input logic [7:0] col, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(xh);
        send_byte(xl);
        send_byte(yh);
        send_byte(yl);
        send_byte(col);
        send_byte(chk);
    endtask

    task automatic test_reset();
        tick();
        tick();
        total_cnt++;
        if (PIX_VLD !== 1'b0) $display("FAIL reset_vld: got %b want 0", PIX_VLD);
        else pass_cnt++;
        total_cnt++;
        if ({PIX_X, PIX_Y, PIX_COLOR} !== 28'd0)
            $display("FAIL reset_pix: got %h want 0", {PIX_X, PIX_Y, PIX_COLOR});
        else pass_cnt++;
        total_cnt++;
        if ({FRAME_ERR, FRAME_OVF, STAT_FRAMES, STAT_ERRORS} !== 34'd0)
            $display("FAIL reset_flags: got %h want 0",
                     {FRAME_ERR, FRAME_OVF, STAT_FRAMES, STAT_ERRORS});
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== 3'd0) $display("FAIL reset_state: got %0d want 0", dut.state_q);
        else pass_cnt++;
        SYS_RST = 1'b0;
        tick();
    endtask

    task automatic test_idle_ignore();
        int e0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'h12);
        RX_ERR = 1'b1;
        tick();
        RX_ERR = 1'b0;
        tick();
        total_cnt++;
        if (err_cnt !== e0) $display("FAIL idle_ignore_err: got %0d want %0d", err_cnt, e0);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== 3'd0) $display("FAIL idle_ignore_state: got %0d want 0", dut.state_q);
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        exp_frames++;
        total_cnt++;
        if ({PIX_VLD, PIX_X, PIX_Y, PIX_COLOR} !== {1'b1, 10'd319, 10'd239, 8'hC3})
            $display("FAIL good_pix: got vld=%b x=%0d y=%0d c=%h want 1 319 239 c3",
                     PIX_VLD, PIX_X, PIX_Y, PIX_COLOR);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PIX_VLD !== 1'b0) $display("FAIL good_vld_drop: got %b want 0", PIX_VLD);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - w0 !== 1 || err_cnt !== e0)
            $display("FAIL good_counts: got wr=%0d err=%0d want 1 0", wr_cnt - w0, err_cnt - e0);
        else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h13);
        exp_errs++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD} !== 2'b10)
            $display("FAIL badchk_err: got err=%b vld=%b want 1 0", FRAME_ERR, PIX_VLD);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== 3'd0) $display("FAIL badchk_state: got %0d want 0", dut.state_q);
        else pass_cnt++;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        exp_frames++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD, PIX_X} !== {1'b0, 1'b1, 10'd319})
            $display("FAIL badchk_recover: got err=%b vld=%b x=%0d want 0 1 319",
                     FRAME_ERR, PIX_VLD, PIX_X);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_limits();
        send_frame(8'h02, 8'h80, 8'h00, 8'hEF, 8'hC3, 8'hAE);
        exp_errs++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD} !== 2'b10)
            $display("FAIL x640: got err=%b vld=%b want 1 0", FRAME_ERR, PIX_VLD);
        else pass_cnt++;
        send_frame(8'h02, 8'h7F, 8'h00, 8'hEF, 8'hC3, 8'h51);
        exp_frames++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD, PIX_X} !== {1'b0, 1'b1, 10'd639})
            $display("FAIL x639: got err=%b vld=%b x=%0d want 0 1 639", FRAME_ERR, PIX_VLD, PIX_X);
        else pass_cnt++;
        tick();
        send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04);
        exp_errs++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD} !== 2'b10)
            $display("FAIL xh_high_bits: got err=%b vld=%b want 1 0", FRAME_ERR, PIX_VLD);
        else pass_cnt++;
        send_frame(8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'hE1);
        exp_errs++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD} !== 2'b10)
            $display("FAIL y480: got err=%b vld=%b want 1 0", FRAME_ERR, PIX_VLD);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_sof_as_data();
        send_frame(8'h01, 8'hA5, 8'h00, 8'h10, 8'hA5, 8'h11);
        exp_frames++;
        total_cnt++;
        if ({PIX_VLD, PIX_X, PIX_Y, PIX_COLOR} !== {1'b1, 10'd421, 10'd16, 8'hA5})
            $display("FAIL sof_data: got vld=%b x=%0d y=%0d c=%h want 1 421 16 a5",
                     PIX_VLD, PIX_X, PIX_Y, PIX_COLOR);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        send_byte(8'hA5);
        send_byte(8'h01);
        while (FRAME_ERR !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        exp_errs++;
        total_cnt++;
        if (n !== 200) $display("FAIL timeout_cycles: got %0d want 200", n);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== 3'd0) $display("FAIL timeout_state: got %0d want 0", dut.state_q);
        else pass_cnt++;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        exp_frames++;
        total_cnt++;
        if ({PIX_VLD, PIX_X, PIX_Y} !== {1'b1, 10'd319, 10'd239})
            $display("FAIL timeout_recover: got vld=%b x=%0d y=%0d want 1 319 239",
                     PIX_VLD, PIX_X, PIX_Y);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        int w0;
        PIX_RDY = 1'b0;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        send_frame(8'h00, 8'h10, 8'h00, 8'h20, 8'h55, 8'h65);
        exp_frames += 2;
        exp_errs++;
        total_cnt++;
        if ({FRAME_OVF, FRAME_ERR, PIX_VLD, PIX_X, PIX_COLOR} !== {3'b101, 10'd319, 8'hC3})
            $display("FAIL ovf_pulse: got ovf=%b err=%b vld=%b x=%0d c=%h want 1 0 1 319 c3",
                     FRAME_OVF, FRAME_ERR, PIX_VLD, PIX_X, PIX_COLOR);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({FRAME_OVF, PIX_VLD} !== 2'b01)
            $display("FAIL ovf_width: got ovf=%b vld=%b want 0 1", FRAME_OVF, PIX_VLD);
        else pass_cnt++;
        w0 = wr_cnt;
        PIX_RDY = 1'b1;
        tick();
        total_cnt++;
        if (PIX_VLD !== 1'b0 || wr_cnt - w0 !== 1 || wr_x !== 10'd319)
            $display("FAIL ovf_drain: got vld=%b wr=%0d x=%0d want 0 1 319",
                     PIX_VLD, wr_cnt - w0, wr_x);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w0;
        int o0 = ovf_cnt;
        PIX_RDY = 1'b0;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h55);
        PIX_RDY = 1'b1;
        send_byte(8'h65);
        exp_frames += 2;
        total_cnt++;
        if ({PIX_VLD, FRAME_OVF, PIX_X, PIX_Y, PIX_COLOR} !== {2'b10, 10'd16, 10'd32, 8'h55})
            $display("FAIL b2b_reload: got vld=%b ovf=%b x=%0d y=%0d c=%h want 1 0 16 32 55",
                     PIX_VLD, FRAME_OVF, PIX_X, PIX_Y, PIX_COLOR);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - w0 !== 1 || wr_x !== 10'd319)
            $display("FAIL b2b_first: got wr=%0d x=%0d want 1 319", wr_cnt - w0, wr_x);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (PIX_VLD !== 1'b0 || wr_x !== 10'd16 || wr_c !== 8'h55 || ovf_cnt !== o0)
            $display("FAIL b2b_second: got vld=%b x=%0d c=%h ovf=%0d want 0 16 55 %0d",
                     PIX_VLD, wr_x, wr_c, ovf_cnt, o0);
        else pass_cnt++;
    endtask

    task automatic test_rx_err();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h3F);
        send_byte(8'h00);
        RX_ERR = 1'b1;
        send_byte(8'hEF);
        RX_ERR = 1'b0;
        exp_errs++;
        total_cnt++;
        if ({FRAME_ERR, PIX_VLD} !== 2'b10)
            $display("FAIL rxerr_err: got err=%b vld=%b want 1 0", FRAME_ERR, PIX_VLD);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== 3'd0) $display("FAIL rxerr_state: got %0d want 0", dut.state_q);
        else pass_cnt++;
        tick();
        tick();
`ifdef UART_PIX_CMD_STATS_EN
        total_cnt++;
        if (STAT_ERRORS !== 16'(exp_errs) || STAT_FRAMES !== 16'(exp_frames))
            $display("FAIL stats: got frames=%0d errors=%0d want %0d %0d",
                     STAT_FRAMES, STAT_ERRORS, exp_frames, exp_errs);
        else pass_cnt++;
`else
        total_cnt++;
        if ({STAT_FRAMES, STAT_ERRORS} !== 32'd0)
            $display("FAIL stats_tied: got frames=%0d errors=%0d want 0 0",
                     STAT_FRAMES, STAT_ERRORS);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_midframe();
        PIX_RDY = 1'b0;
        send_frame(8'h01, 8'h3F, 8'h00, 8'hEF, 8'hC3, 8'h12);
        send_byte(8'hA5);
        send_byte(8'h01);
        SYS_RST = 1'b1;
        #1;
        total_cnt++;
        if ({PIX_VLD, PIX_X, STAT_FRAMES} !== 27'd0 || dut.state_q !== 3'd0)
            $display("FAIL reset_mid: got vld=%b x=%0d frames=%0d state=%0d want 0 0 0 0",
                     PIX_VLD, PIX_X, STAT_FRAMES, dut.state_q);
        else pass_cnt++;
        tick();
        SYS_RST = 1'b0;
        PIX_RDY = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good_frame();
        test_bad_checksum();
        test_limits();
        test_sof_as_data();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_rx_err();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
